avalon_mem_slave: RTL and testbench
===================================

Name: avalon_mem_slave

Overview:
Parametrised Avalon-MM slave memory for CPU bus-level benches and system integration. It replaces hand-driven readdata/waitrequest stimulus with a word-addressed RAM that has a programmable wait-state count, byteenable-masked writes and address-window checking. It also provides a backdoor preload port and transfer counters so benches can load programs and check bus traffic.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
BE_WIDTH, DATA_WIDTH/8, byteenable width; derived, not overridden.
DEPTH_LOG2, 10, log2 of memory depth in words.
BASE_ADDR, 32'hBFC00000, byte address of word 0.
WAIT_CYCLES, 1, waitrequest-high cycles per transfer (0..15).
CNT_WIDTH, 16, width of the transfer counters.

Ports:
clk  input  1  system clock; all state changes on posedge.
reset  input  1  asynchronous, active-high reset.
address  input  32  byte address from the master.
read  input  1  read request.
write  input  1  write request.
writedata  input  DATA_WIDTH  write data.
byteenable  input  BE_WIDTH  byte lane enables for writes.
waitrequest  output  1  slave stall.
readdata  output  DATA_WIDTH  read data; valid when read=1 and waitrequest=0.
init_we  input  1  backdoor word write, ignores bus state.
init_addr  input  DEPTH_LOG2  backdoor word index.
init_data  input  DATA_WIDTH  backdoor data.
err  output  1  sticky error flag.
rd_count  output  CNT_WIDTH  completed reads.
wr_count  output  CNT_WIDTH  completed writes.

Behaviour:
- Reset values: FSM=IDLE, wait counter=0, err=0, rd_count=0, wr_count=0. Memory contents are not cleared.
- Word index = (address - BASE_ADDR) >> 2.
- In range: 0 <= address - BASE_ADDR < 4*2^DEPTH_LOG2. Unsigned compare; no wrap.
- readdata is combinational from mem[index] when read=1, in range and aligned; otherwise 0.
- waitrequest is combinational: (read|write) && state!=ACK. With WAIT_CYCLES=0, waitrequest=0 whenever the request is present.
- FSM:
  - IDLE: request seen → WAIT, counter loaded with WAIT_CYCLES-1. If WAIT_CYCLES=0, complete in the same cycle and stay in IDLE.
  - WAIT: counter decrements each cycle; at 0 → ACK.
  - ACK: transfer completes at this edge → IDLE.
- A transfer therefore takes WAIT_CYCLES+1 cycles. Back-to-back requests restart from IDLE with no idle gap.
- Write at completion: byte lane i updated iff byteenable[i]=1; other lanes keep their value. wr_count increments by 1.
- Read at completion: rd_count increments by 1.
- Counters wrap modulo 2^CNT_WIDTH.
- Error completion: err set and held until reset; no memory update; readdata=0; the transfer still completes with normal timing and is not counted. Error conditions are:
  - read and write both high;
  - address[1:0] != 0;
  - address out of range.
- Request dropped while in WAIT: abort, go to IDLE, nothing counted or written. Address or data changes during WAIT are sampled at completion.
- Simultaneous init_we and a bus write to the same word in the same cycle: init_we wins. init_we never stalls the bus.
- Reset asserted mid-transfer: immediate return to IDLE; any pending write is discarded.

Test Plan:
- WAIT_CYCLES=1, preload word0=32'h24810020, read 32'hBFC00000 → waitrequest high 1 cycle then low; readdata=32'h24810020; rd_count=1.
- Preload word1=32'hBB00AA00, write 32'h11223344 to 32'hBFC00004 with byteenable=4'b0101 → readback 32'hBB22AA44; wr_count=1.
- WAIT_CYCLES=0, 8 back-to-back reads of words 0..7 → waitrequest never high; 8 completions in 8 cycles; rd_count=8.
- Read 32'hBFC00002 and read 32'h00000000 → err=1 after the first; readdata=0; rd_count unchanged; err stays set.
- WAIT_CYCLES=3, write asserted then dropped after 2 cycles → memory unchanged; wr_count=0; FSM back to IDLE.
- Reset pulse during WAIT of a write → waitrequest=0 immediately; counters=0; target word unchanged.

Source files
------------

// File: rtl/avalon_mem_slave.sv
// Avalon-MM slave RAM with a programmable wait-state count, byte-lane writes,
// address-window checking, a backdoor preload port and transfer counters.
module avalon_mem_slave #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          BE_WIDTH    = DATA_WIDTH / 8,
  parameter int          DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          WAIT_CYCLES = 1,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           address,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata,
  input  logic [BE_WIDTH-1:0]   byteenable,
  output logic                  waitrequest,
  output logic [DATA_WIDTH-1:0] readdata,
  input  logic                  init_we,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0] init_data,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // The IDLE cycle that sees the request is the first wait cycle.
  localparam logic [3:0] LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t                 state_reg;
  logic [3:0]             cnt_reg;
  logic                   err_reg;
  logic [CNT_WIDTH-1:0]   rd_count_reg;
  logic [CNT_WIDTH-1:0]   wr_count_reg;

  logic [31:0]            offset;
  logic                   in_range;
  logic                   aligned;
  logic                   bad;
  logic                   req;
  logic                   done;
  logic                   wr_fire;
  logic                   rd_fire;
  logic [DEPTH_LOG2-1:0]  index;
  logic [DATA_WIDTH-1:0]  rd_word;

  // BASE_ADDR is word aligned, so offset[1:0] equals address[1:0].
  assign offset   = address - BASE_ADDR;
  assign in_range = (offset[31:DEPTH_LOG2+2] == '0);
  assign aligned  = (offset[1:0] == 2'b00);
  assign index    = offset[DEPTH_LOG2+1:2];
  assign req      = read | write;
  assign bad      = (read & write) | ~aligned | ~in_range;

  // With zero wait states the transfer completes in the IDLE cycle itself.
  assign done     = req && !reset && ((WAIT_CYCLES == 0) || (state_reg == S_ACK));
  assign wr_fire  = done && write && !bad;
  assign rd_fire  = done && read && !bad;

  assign waitrequest = req && !reset && (WAIT_CYCLES != 0) && (state_reg != S_ACK);
  assign readdata    = (read && !bad) ? rd_word : '0;

  assign err      = err_reg;
  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // The backdoor write is issued last so it overrides a bus write to the same word.
      always_ff @(posedge clk) begin
        if (wr_fire && byteenable[gi]) begin
          lane_mem[index] <= writedata[gi*8 +: 8];
        end
        if (init_we) begin
          lane_mem[init_addr] <= init_data[gi*8 +: 8];
        end
      end

      assign rd_word[gi*8 +: 8] = lane_mem[index];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= 4'd0;
      err_reg      <= 1'b0;
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      if (done && bad) begin
        err_reg <= 1'b1;
      end
      if (rd_fire) begin
        rd_count_reg <= rd_count_reg + 1'b1;
      end
      if (wr_fire) begin
        wr_count_reg <= wr_count_reg + 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (req && (WAIT_CYCLES != 0)) begin
            cnt_reg   <= LOAD;
            state_reg <= (LOAD == 4'd0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
          end else if (cnt_reg <= 4'd1) begin
            cnt_reg   <= 4'd0;
            state_reg <= S_ACK;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        S_ACK: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          cnt_reg   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mem_slave.sv
// Directed bench for avalon_mem_slave: three instances (0, 1 and 3 wait states)
// share one bus; sel picks the instance whose outputs are checked.
module tb_avalon_mem_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        init_we = 1'b0;
  logic [9:0]  init_addr = '0;
  logic [31:0] init_data = '0;

  logic        waitreq [3];
  logic [31:0] rdata   [3];
  logic        errf    [3];
  logic [15:0] rdc     [3];
  logic [15:0] wrc     [3];

  int tests = 0;
  int fails = 0;
  int sel   = 1;

  always #5 clk = ~clk;

  avalon_mem_slave #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitreq[0]),
    .readdata(rdata[0]), .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data), .err(errf[0]), .rd_count(rdc[0]), .wr_count(wrc[0]));

  avalon_mem_slave #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitreq[1]),
    .readdata(rdata[1]), .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data), .err(errf[1]), .rd_count(rdc[1]), .wr_count(wrc[1]));

  avalon_mem_slave #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitreq[2]),
    .readdata(rdata[2]), .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data), .err(errf[2]), .rd_count(rdc[2]), .wr_count(wrc[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus transfer; returns stall cycles, read data seen at completion and completion cycle.
  task automatic bus(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] be,
                     output int stall, output logic [31:0] data_o, output int done_cyc);
    stall  = 0;
    data_o = '0;
    @(negedge clk);
    read = rd; write = wr; address = addr; writedata = data; byteenable = be;
    #1;
    while (waitreq[sel]) begin
      stall++;
      if (stall > 32) begin
        check("timeout", stall, 32);
        break;
      end
      @(negedge clk);
      #1;
    end
    data_o = rdata[sel];
    @(posedge clk);
    done_cyc = int'($time / 10);
    $display("[TB] dut%0d %s addr=0x%08h wdata=0x%08h be=%b stall=%0d rdata=0x%08h",
             sel, wr ? (rd ? "rw" : "wr") : "rd", addr, data, be, stall, data_o);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    #1;
  endtask

  // Look at readdata combinationally and withdraw the request before the next edge.
  task automatic peek(input logic [31:0] addr, output logic [31:0] data_o);
    @(negedge clk);
    write = 1'b0; read = 1'b1; address = addr;
    #1;
    data_o = rdata[sel];
    read = 1'b0;
    $display("[TB] dut%0d peek addr=0x%08h data=0x%08h", sel, addr, data_o);
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    init_we = 1'b1; init_addr = idx; init_data = data;
    @(negedge clk);
    init_we = 1'b0;
    $display("[TB] preload word %0d = 0x%08h", idx, data);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stall;
    int          t_first;
    int          t_last;
    int          t_now;
    logic [31:0] d;
    logic [31:0] exp_mem [8];

    #12;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      check("rst_wait", {31'b0, waitreq[k]}, 32'd0);
      check("rst_err",  {31'b0, errf[k]},    32'd0);
      check("rst_rdc",  {16'b0, rdc[k]},     32'd0);
      check("rst_wrc",  {16'b0, wrc[k]},     32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // One wait state: read, then byte-masked write and readback.
    sel = 1;
    preload(10'd0, 32'h24810020);
    preload(10'd1, 32'hBB00AA00);
    bus(1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'h0, stall, d, t_now);
    bus_idle();
    check("w1_rd_stall", stall, 32'd1);
    check("w1_rd_data",  d, 32'h24810020);
    check("w1_rdc",      {16'b0, rdc[1]}, 32'd1);

    bus(1'b0, 1'b1, 32'hBFC00004, 32'h11223344, 4'b0101, stall, d, t_now);
    bus_idle();
    check("w1_wr_stall", stall, 32'd1);
    check("w1_wrc",      {16'b0, wrc[1]}, 32'd1);
    bus(1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'h0, stall, d, t_now);
    bus_idle();
    check("w1_be_data",  d, 32'hBB22AA44);
    check("w1_rdc2",     {16'b0, rdc[1]}, 32'd2);

    // Zero wait states: eight back-to-back reads.
    sel = 0;
    exp_mem[0] = 32'h24810020;
    exp_mem[1] = 32'hBB00AA00;
    for (int k = 2; k < 8; k++) begin
      exp_mem[k] = 32'h10000000 + k;
      preload(10'(k), exp_mem[k]);
    end
    pulse_reset();
    preload(10'd1, 32'hBB00AA00);
    t_first = 0;
    t_last  = 0;
    for (int k = 0; k < 8; k++) begin
      bus(1'b1, 1'b0, 32'hBFC00000 + 32'(4 * k), 32'h0, 4'h0, stall, d, t_now);
      if (k == 0) t_first = t_now;
      t_last = t_now;
      check("w0_stall", stall, 32'd0);
      check("w0_data",  d, exp_mem[k]);
    end
    bus_idle();
    check("w0_cycles", t_last - t_first, 32'd7);
    check("w0_rdc",    {16'b0, rdc[0]}, 32'd8);

    // Same-cycle backdoor and bus write to word 7: backdoor data must survive.
    @(negedge clk);
    init_we = 1'b1; init_addr = 10'd7; init_data = 32'h77777777;
    write = 1'b1; address = 32'hBFC0001C; writedata = 32'h0; byteenable = 4'hF;
    #1;
    check("w0_init_nostall", {31'b0, waitreq[0]}, 32'd0);
    @(negedge clk);
    init_we = 1'b0; write = 1'b0;
    $display("[TB] dut0 wr+init addr=0xbfc0001c");
    peek(32'hBFC0001C, d);
    check("w0_init_wins", d, 32'h77777777);
    check("w0_wrc",       {16'b0, wrc[0]}, 32'd1);

    // Window boundaries and error handling.
    sel = 1;
    pulse_reset();
    preload(10'd1023, 32'hCAFEF00D);
    bus(1'b1, 1'b0, 32'hBFC00FFC, 32'h0, 4'h0, stall, d, t_now);
    bus_idle();
    check("last_word",   d, 32'hCAFEF00D);
    check("last_noerr",  {31'b0, errf[1]}, 32'd0);
    bus(1'b1, 1'b0, 32'hBFC00002, 32'h0, 4'h0, stall, d, t_now);
    bus_idle();
    check("misal_data",  d, 32'h0);
    check("misal_stall", stall, 32'd1);
    check("misal_err",   {31'b0, errf[1]}, 32'd1);
    check("misal_rdc",   {16'b0, rdc[1]}, 32'd1);
    bus(1'b1, 1'b0, 32'h00000000, 32'h0, 4'h0, stall, d, t_now);
    bus_idle();
    check("low_data",    d, 32'h0);
    check("low_err",     {31'b0, errf[1]}, 32'd1);
    check("low_rdc",     {16'b0, rdc[1]}, 32'd1);
    bus(1'b1, 1'b0, 32'hBFC01000, 32'h0, 4'h0, stall, d, t_now);
    bus_idle();
    check("past_end",    d, 32'h0);
    check("past_rdc",    {16'b0, rdc[1]}, 32'd1);
    bus(1'b1, 1'b1, 32'hBFC00008, 32'hFFFFFFFF, 4'hF, stall, d, t_now);
    bus_idle();
    check("rw_data",     d, 32'h0);
    check("rw_wrc",      {16'b0, wrc[1]}, 32'd0);
    peek(32'hBFC00008, d);
    check("rw_nowrite",  d, 32'h10000002);

    // Three wait states: aborted write, then a full write.
    sel = 2;
    pulse_reset();
    @(negedge clk);
    write = 1'b1; address = 32'hBFC00008; writedata = 32'hDEADBEEF; byteenable = 4'hF;
    #1;
    check("abort_wait0", {31'b0, waitreq[2]}, 32'd1);
    @(negedge clk);
    #1;
    check("abort_wait1", {31'b0, waitreq[2]}, 32'd1);
    @(negedge clk);
    write = 1'b0;
    $display("[TB] dut2 wr addr=0xbfc00008 dropped after 2 cycles");
    peek(32'hBFC00008, d);
    check("abort_mem",   d, 32'h10000002);
    check("abort_wrc",   {16'b0, wrc[2]}, 32'd0);
    bus(1'b0, 1'b1, 32'hBFC0000C, 32'h55667788, 4'hF, stall, d, t_now);
    bus_idle();
    check("w3_stall",    stall, 32'd3);
    check("w3_wrc",      {16'b0, wrc[2]}, 32'd1);
    peek(32'hBFC0000C, d);
    check("w3_mem",      d, 32'h55667788);

    // Reset in the middle of a write.
    @(negedge clk);
    write = 1'b1; address = 32'hBFC00010; writedata = 32'hFFFFFFFF; byteenable = 4'hF;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_wait", {31'b0, waitreq[2]}, 32'd0);
    write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    $display("[TB] dut2 wr addr=0xbfc00010 interrupted by reset");
    check("rst_mid_wrc", {16'b0, wrc[2]}, 32'd0);
    check("rst_mid_rdc", {16'b0, rdc[2]}, 32'd0);
    check("rst_mid_err", {31'b0, errf[2]}, 32'd0);
    peek(32'hBFC00010, d);
    check("rst_mid_mem", d, 32'h10000004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
